mips_reg_wb_arbiter: RTL and testbench



---
 rtl/mips_reg_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_mips_reg_wb_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mips_reg_wb_arbiter.sv
// Round-robin write-port arbiter for the MIPS register file: two requester FIFOs feed one registered write port.
// Optional build macro REGWB_ZERO_LOCK_EN suppresses the write strobe for entries targeting register 0.
module mips_reg_wb_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [DATA_W-1:0] WriteData,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} grant_e;

  // Index 0 is requester A, index 1 is requester B.
  logic [1:0]       in_valid_s;
  logic [ENT_W-1:0] in_entry_s [2];
  logic [1:0]       push_s;
  logic [1:0]       pop_s;
  logic [1:0]       nonempty_s;
  logic [ENT_W-1:0] head_s;

  logic [ENT_W-1:0] mem_q    [2][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [2];
  logic [PTR_W-1:0] wr_ptr_d [2];
  logic [PTR_W-1:0] rd_ptr_q [2];
  logic [PTR_W-1:0] rd_ptr_d [2];
  logic [CNT_W-1:0] cnt_q    [2];
  logic [CNT_W-1:0] cnt_d    [2];
  logic [1:0]       ready_q;
  logic [1:0]       ready_d;

  grant_e           last_grant_q;
  grant_e           last_grant_d;
  logic             reg_write_q;
  logic             reg_write_d;
  logic [ADDR_W-1:0] write_addr_q;
  logic [ADDR_W-1:0] write_addr_d;
  logic [DATA_W-1:0] write_data_q;
  logic [DATA_W-1:0] write_data_d;

  assign in_valid_s    = {b_valid, a_valid};
  assign in_entry_s[0] = {a_addr, a_data};
  assign in_entry_s[1] = {b_addr, b_data};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      nonempty_s[i] = (cnt_q[i] != {CNT_W{1'b0}});
      push_s[i]     = in_valid_s[i] && ready_q[i];
    end

    // Contended cycles go to the requester opposite the previous grant.
    if (nonempty_s[0] && (!nonempty_s[1] || (last_grant_q == GNT_B))) begin
      pop_s = 2'b01;
    end else if (nonempty_s[1]) begin
      pop_s = 2'b10;
    end else begin
      pop_s = 2'b00;
    end

    for (int i = 0; i < 2; i++) begin
      cnt_d[i]    = cnt_q[i] + CNT_W'(push_s[i]) - CNT_W'(pop_s[i]);
      wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push_s[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop_s[i]);
      ready_d[i]  = (cnt_d[i] != CNT_W'(FIFO_DEPTH));
    end

    if (pop_s[1]) begin
      head_s = mem_q[1][rd_ptr_q[1]];
    end else begin
      head_s = mem_q[0][rd_ptr_q[0]];
    end

    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (pop_s != 2'b00) begin
      last_grant_d = pop_s[1] ? GNT_B : GNT_A;
      write_addr_d = head_s[ENT_W-1:DATA_W];
      write_data_d = head_s[DATA_W-1:0];
`ifdef REGWB_ZERO_LOCK_EN
      reg_write_d  = (head_s[ENT_W-1:DATA_W] != {ADDR_W{1'b0}});
`else
      reg_write_d  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          mem_q[i][j] <= {ENT_W{1'b0}};
        end
        wr_ptr_q[i] <= {PTR_W{1'b0}};
        rd_ptr_q[i] <= {PTR_W{1'b0}};
        cnt_q[i]    <= {CNT_W{1'b0}};
      end
      ready_q      <= 2'b11;
      last_grant_q <= GNT_B;
      reg_write_q  <= 1'b0;
      write_addr_q <= {ADDR_W{1'b0}};
      write_data_q <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push_s[i]) begin
          mem_q[i][wr_ptr_q[i]] <= in_entry_s[i];
        end
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      ready_q      <= ready_d;
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign a_ready   = ready_q[0];
  assign b_ready   = ready_q[1];
  assign RegWrite  = reg_write_q;
  assign WriteAddr = write_addr_q;
  assign WriteData = write_data_q;
  assign busy      = (|nonempty_s) | reg_write_q;

endmodule

// File: tb/tb_mips_reg_wb_arbiter.sv
// Directed self-checking bench for mips_reg_wb_arbiter; expectations follow REGWB_ZERO_LOCK_EN when defined.
module tb_mips_reg_wb_arbiter;

  logic       clk;
  logic       rst;
  logic       a_valid;
  logic       a_ready;
  logic [2:0] a_addr;
  logic [7:0] a_data;
  logic       b_valid;
  logic       b_ready;
  logic [2:0] b_addr;
  logic [7:0] b_data;
  logic       RegWrite;
  logic [2:0] WriteAddr;
  logic [7:0] WriteData;
  logic       busy;

  int checks = 0;
  int errors = 0;

  mips_reg_wb_arbiter #(.DATA_W(8), .ADDR_W(3), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic rw, input logic [2:0] ad, input logic [7:0] da);
    check({tag, ".rw"}, {31'd0, RegWrite}, {31'd0, rw});
    check({tag, ".addr"}, {29'd0, WriteAddr}, {29'd0, ad});
    check({tag, ".data"}, {24'd0, WriteData}, {24'd0, da});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_a(input logic v, input logic [2:0] ad, input logic [7:0] da);
    a_valid = v; a_addr = ad; a_data = da;
  endtask

  task automatic set_b(input logic v, input logic [2:0] ad, input logic [7:0] da);
    b_valid = v; b_addr = ad; b_data = da;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic zl_rw;
    rst = 1'b1;
    set_a(1'b0, 3'd0, 8'h00);
    set_b(1'b0, 3'd0, 8'h00);
    tick();
    do_reset();

    // Reset state
    check_wr("rst_state", 1'b0, 3'd0, 8'h00);
    check("rst_a_ready", {31'd0, a_ready}, 32'd1);
    check("rst_b_ready", {31'd0, b_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Single write
    set_a(1'b1, 3'd3, 8'h5A);
    tick();
    set_a(1'b0, 3'd0, 8'h00);
    check("single_pre_rw", {31'd0, RegWrite}, 32'd0);
    check("single_pre_busy", {31'd0, busy}, 32'd1);
    tick();
    check_wr("single_wr", 1'b1, 3'd3, 8'h5A);
    tick();
    check_wr("single_after", 1'b0, 3'd3, 8'h5A);
    check("single_busy", {31'd0, busy}, 32'd0);

    // Contention: expected writes 1,4,2,5
    do_reset();
    set_a(1'b1, 3'd1, 8'h11);
    set_b(1'b1, 3'd4, 8'h44);
    tick();
    set_a(1'b1, 3'd2, 8'h22);
    set_b(1'b1, 3'd5, 8'h55);
    tick();
    set_a(1'b0, 3'd0, 8'h00);
    set_b(1'b0, 3'd0, 8'h00);
    check_wr("cont_w0", 1'b1, 3'd1, 8'h11);
    tick();
    check_wr("cont_w1", 1'b1, 3'd4, 8'h44);
    tick();
    check_wr("cont_w2", 1'b1, 3'd2, 8'h22);
    tick();
    check_wr("cont_w3", 1'b1, 3'd5, 8'h55);
    tick();
    check_wr("cont_end", 1'b0, 3'd5, 8'h55);
    check("cont_busy", {31'd0, busy}, 32'd0);

    // Backpressure: B fills, b2 held until ready returns
    do_reset();
    set_a(1'b1, 3'd1, 8'hA0);
    set_b(1'b1, 3'd4, 8'hB0);
    tick();
    check("bp_b_ready_e1", {31'd0, b_ready}, 32'd1);
    check("bp_rw_e1", {31'd0, RegWrite}, 32'd0);
    set_a(1'b1, 3'd2, 8'hA1);
    set_b(1'b1, 3'd5, 8'hB1);
    tick();
    check("bp_b_ready_full", {31'd0, b_ready}, 32'd0);
    check_wr("bp_w0", 1'b1, 3'd1, 8'hA0);
    set_a(1'b1, 3'd3, 8'hA2);
    set_b(1'b1, 3'd6, 8'hB2);
    tick();
    check_wr("bp_w1", 1'b1, 3'd4, 8'hB0);
    check("bp_b_ready_back", {31'd0, b_ready}, 32'd1);
    check("bp_a_ready_full", {31'd0, a_ready}, 32'd0);
    set_a(1'b0, 3'd0, 8'h00);
    tick();
    set_b(1'b0, 3'd0, 8'h00);
    check_wr("bp_w2", 1'b1, 3'd2, 8'hA1);
    check("bp_b_ready_full2", {31'd0, b_ready}, 32'd0);
    tick();
    check_wr("bp_w3", 1'b1, 3'd5, 8'hB1);
    tick();
    check_wr("bp_w4", 1'b1, 3'd3, 8'hA2);
    tick();
    check_wr("bp_w5", 1'b1, 3'd6, 8'hB2);
    tick();
    check_wr("bp_end", 1'b0, 3'd6, 8'hB2);
    check("bp_busy", {31'd0, busy}, 32'd0);

    // Reset mid-stream with two entries queued in A
    do_reset();
    set_a(1'b1, 3'd1, 8'h01);
    set_b(1'b1, 3'd4, 8'h04);
    tick();
    set_a(1'b1, 3'd2, 8'h02);
    set_b(1'b0, 3'd0, 8'h00);
    tick();
    set_a(1'b1, 3'd3, 8'h03);
    tick();
    set_a(1'b0, 3'd0, 8'h00);
    check("mid_rw_before", {31'd0, RegWrite}, 32'd1);
    check("mid_a_full", {31'd0, a_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rw_async", {31'd0, RegWrite}, 32'd0);
    check("mid_busy_async", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    check("mid_a_ready", {31'd0, a_ready}, 32'd1);
    check("mid_b_ready", {31'd0, b_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_no_write", {31'd0, RegWrite}, 32'd0);
      check("mid_busy", {31'd0, busy}, 32'd0);
    end

    // Zero-lock slot
`ifdef REGWB_ZERO_LOCK_EN
    zl_rw = 1'b0;
`else
    zl_rw = 1'b1;
`endif
    do_reset();
    set_a(1'b1, 3'd0, 8'hFF);
    tick();
    set_a(1'b1, 3'd6, 8'h66);
    tick();
    set_a(1'b0, 3'd0, 8'h00);
    check_wr("zl_slot0", zl_rw, 3'd0, 8'hFF);
    tick();
    check_wr("zl_slot1", 1'b1, 3'd6, 8'h66);
    tick();
    check_wr("zl_end", 1'b0, 3'd6, 8'h66);
    check("zl_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
